// File: rtl/mem_dtack_arbiter_pkg.sv
// Shared types and constants for the memory DTACK arbiter.
package mem_dtack_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    WAITST  = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } mem_arb_state_t;

  localparam int MAX_NCH = 8;
  localparam int WAIT_W  = 4;

endpackage

// File: rtl/mem_dtack_arbiter_rr_select.sv
// Combinational round-robin picker: first requester strictly after i_ptr, one-hot out.
module rr_select
  import mem_dtack_arbiter_pkg::*;
#(
  parameter int NCH = 3,
  parameter int PW  = 2
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant
);

  logic [2*NCH-1:0] w_req2;
  logic [2*NCH-1:0] w_gnt2;
  logic [NCH-1:0]   w_rot;
  logic [NCH-1:0]   w_pick;
  logic [PW:0]      w_sh;
  logic             w_found;

  // Rotate so the channel after the pointer sits at bit 0; a shift of NCH wraps to ch0.
  assign w_sh   = {1'b0, i_ptr} + {{PW{1'b0}}, 1'b1};
  assign w_req2 = {i_req, i_req};
  assign w_rot  = NCH'(w_req2 >> w_sh);

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_rot[i] && !w_found) begin
        w_pick[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  // Rotate the pick back and fold the wrapped half onto the low half.
  assign w_gnt2  = {{NCH{1'b0}}, w_pick} << w_sh;
  assign o_grant = w_gnt2[NCH-1:0] | w_gnt2[2*NCH-1:NCH];

endmodule

// File: rtl/mem_dtack_arbiter.sv
// Multi-channel SRAM arbiter with 68K-style active-low DTACK handshake.
//
// state   | meaning
// IDLE    | no access; arbitrate among low CE_N bits
// ACCESS  | RAM strobe cycle, then one cycle for RAM read latency
// WAITST  | extra wait cycles (down-counter to terminal count 1)
// ACK     | DTACK low for granted channel until its CE_N goes high
// RELEASE | one dead cycle before re-arbitrating
module mem_dtack_arbiter
  import mem_dtack_arbiter_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int AW   = 15,
  parameter int DW   = 16,
  parameter int WAIT = 0
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [NCH-1:0]    REQ_CE_N,
  input  logic [NCH-1:0]    REQ_WE_N,
  input  logic [NCH-1:0]    REQ_UB_N,
  input  logic [NCH-1:0]    REQ_LB_N,
  input  logic [NCH*AW-1:0] REQ_ADDR,
  input  logic [NCH*DW-1:0] REQ_DI,
  output logic [DW-1:0]     REQ_DO,
  output logic [NCH-1:0]    REQ_DTACK_N,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [DW-1:0]     MEM_DI,
  output logic              MEM_EN,
  output logic [1:0]        MEM_WE,
  input  logic [DW-1:0]     MEM_DO
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_CNT = WAIT_W'(WAIT);

  mem_arb_state_t    r_state;
  logic [1:0]        r_rst_sync;
  logic [PW-1:0]     r_last;
  logic [WAIT_W-1:0] r_wcnt;
  logic              r_phase;
  logic              r_is_rd;
  logic [NCH-1:0]    r_dtack_n;
  logic              r_mem_en;
  logic [1:0]        r_mem_we;
  logic [AW-1:0]     r_mem_addr;
  logic [DW-1:0]     r_mem_di;
  logic [DW-1:0]     r_req_do;

  logic              w_rst_n;
  logic [NCH-1:0]    w_grant;
  logic [PW-1:0]     w_grant_idx;
  logic [AW-1:0]     w_sel_addr;
  logic [DW-1:0]     w_sel_di;
  logic              w_sel_we_n;
  logic              w_sel_ub_n;
  logic              w_sel_lb_n;
  logic              w_gnt_ce_n;
  logic [NCH-1:0]    w_last_oh;

  // Reset asserts at once, releases after two clock edges.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  rr_select #(.NCH(NCH), .PW(PW)) u_rr_select (
    .i_req   (~REQ_CE_N),
    .i_ptr   (r_last),
    .o_grant (w_grant)
  );

  // Steer the newly granted channel's request fields to the RAM port.
  always_comb begin
    w_grant_idx = '0;
    w_sel_addr  = '0;
    w_sel_di    = '0;
    w_sel_we_n  = 1'b1;
    w_sel_ub_n  = 1'b1;
    w_sel_lb_n  = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = PW'(i);
        w_sel_addr  = REQ_ADDR[i*AW +: AW];
        w_sel_di    = REQ_DI[i*DW +: DW];
        w_sel_we_n  = REQ_WE_N[i];
        w_sel_ub_n  = REQ_UB_N[i];
        w_sel_lb_n  = REQ_LB_N[i];
      end
    end
  end

  // Decode the currently owned channel (last grant) for CE_N watch and DTACK.
  always_comb begin
    w_gnt_ce_n = 1'b1;
    w_last_oh  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_last == PW'(i)) begin
        w_gnt_ce_n   = REQ_CE_N[i];
        w_last_oh[i] = 1'b1;
      end
    end
  end

  // Arbiter FSM with registered RAM-port and handshake outputs.
  always_ff @(posedge CLK100MHZ or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_last     <= PW'(NCH - 1);
      r_wcnt     <= '0;
      r_phase    <= 1'b0;
      r_is_rd    <= 1'b0;
      r_dtack_n  <= '1;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 2'b00;
      r_mem_addr <= '0;
      r_mem_di   <= '0;
      r_req_do   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|(~REQ_CE_N)) begin
            r_state    <= ACCESS;
            r_last     <= w_grant_idx;
            r_phase    <= 1'b0;
            r_is_rd    <= w_sel_we_n;
            r_mem_en   <= 1'b1;
            r_mem_we   <= {~w_sel_we_n & ~w_sel_ub_n, ~w_sel_we_n & ~w_sel_lb_n};
            r_mem_addr <= w_sel_addr;
            r_mem_di   <= w_sel_di;
          end
        end
        ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 2'b00;
          r_phase  <= 1'b1;
          if (w_gnt_ce_n) begin
            r_state <= RELEASE;
          end else if (r_phase) begin
            if (WAIT_CNT != '0) begin
              r_wcnt  <= WAIT_CNT;
              r_state <= WAITST;
            end else begin
              r_state   <= ACK;
              r_dtack_n <= ~w_last_oh;
              if (r_is_rd) r_req_do <= MEM_DO;
            end
          end
        end
        WAITST: begin
          if (w_gnt_ce_n) begin
            r_wcnt  <= '0;
            r_state <= RELEASE;
          end else if (r_wcnt == WAIT_W'(1)) begin
            r_wcnt    <= '0;
            r_state   <= ACK;
            r_dtack_n <= ~w_last_oh;
            if (r_is_rd) r_req_do <= MEM_DO;
          end else begin
            r_wcnt <= r_wcnt - WAIT_W'(1);
          end
        end
        ACK: begin
          if (w_gnt_ce_n) begin
            r_dtack_n <= '1;
            r_state   <= RELEASE;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign REQ_DO      = r_req_do;
  assign REQ_DTACK_N = r_dtack_n;
  assign MEM_ADDR    = r_mem_addr;
  assign MEM_DI      = r_mem_di;
  assign MEM_EN      = r_mem_en;
  assign MEM_WE      = r_mem_we;

endmodule

// File: tb/tb_mem_dtack_arbiter.sv
// Directed bench: DUT A (WAIT=0) and DUT B (WAIT=3), each with its own RAM model.
module tb_mem_dtack_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 15;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ce_a, we_a, ub_a, lb_a, dt_a;
  logic [NCH*AW-1:0] ad_a;
  logic [NCH*DW-1:0] di_a;
  logic [DW-1:0]     do_a, md_a, mo_a;
  logic [AW-1:0]     ma_a;
  logic              me_a;
  logic [1:0]        mw_a;

  logic [NCH-1:0]    ce_b, we_b, ub_b, lb_b, dt_b;
  logic [NCH*AW-1:0] ad_b;
  logic [NCH*DW-1:0] di_b;
  logic [DW-1:0]     do_b, md_b, mo_b;
  logic [AW-1:0]     ma_b;
  logic              me_b;
  logic [1:0]        mw_b;

  mem_dtack_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(0)) u_dut_a (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n),
    .REQ_CE_N(ce_a), .REQ_WE_N(we_a), .REQ_UB_N(ub_a), .REQ_LB_N(lb_a),
    .REQ_ADDR(ad_a), .REQ_DI(di_a), .REQ_DO(do_a), .REQ_DTACK_N(dt_a),
    .MEM_ADDR(ma_a), .MEM_DI(md_a), .MEM_EN(me_a), .MEM_WE(mw_a), .MEM_DO(mo_a)
  );

  mem_dtack_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .WAIT(3)) u_dut_b (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n),
    .REQ_CE_N(ce_b), .REQ_WE_N(we_b), .REQ_UB_N(ub_b), .REQ_LB_N(lb_b),
    .REQ_ADDR(ad_b), .REQ_DI(di_b), .REQ_DO(do_b), .REQ_DTACK_N(dt_b),
    .MEM_ADDR(ma_b), .MEM_DI(md_b), .MEM_EN(me_b), .MEM_WE(mw_b), .MEM_DO(mo_b)
  );

  logic [15:0] ram_a [0:32767];
  logic [15:0] ram_b [0:32767];

  always @(posedge clk) begin
    if (me_a) begin
      if (mw_a[1]) ram_a[ma_a][15:8] <= md_a[15:8];
      if (mw_a[0]) ram_a[ma_a][7:0]  <= md_a[7:0];
      mo_a <= ram_a[ma_a];
    end
    if (me_b) begin
      if (mw_b[1]) ram_b[ma_b][15:8] <= md_b[15:8];
      if (mw_b[0]) ram_b[ma_b][7:0]  <= md_b[7:0];
      mo_b <= ram_b[ma_b];
    end
  end

  int en_a = 0, en_b = 0, ovl_a = 0, ovl_b = 0;
  always @(negedge clk) begin
    if (me_a) en_a++;
    if (me_b) en_b++;
    if ($countones(~dt_a) > 1) ovl_a++;
    if ($countones(~dt_b) > 1) ovl_b++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input int ch, input logic ce, input logic we,
                       input logic ub, input logic lb, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (!b) begin
      ce_a[ch] = ce; we_a[ch] = we; ub_a[ch] = ub; lb_a[ch] = lb;
      ad_a[ch*AW +: AW] = a; di_a[ch*DW +: DW] = d;
    end else begin
      ce_b[ch] = ce; we_b[ch] = we; ub_b[ch] = ub; lb_b[ch] = lb;
      ad_b[ch*AW +: AW] = a; di_b[ch*DW +: DW] = d;
    end
  endtask

  // One complete access: returns RAM-port values after the grant edge, latency in
  // edges after the grant edge, REQ_DO, DTACK after 3 hold cycles and after CE_N rise.
  task automatic do_acc(input bit b, input int ch, input logic we, input logic ub,
                        input logic lb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic f_en, output logic [1:0] f_we,
                        output logic [AW-1:0] f_addr, output logic [DW-1:0] f_di,
                        output int lat, output logic [DW-1:0] rdata,
                        output logic [2:0] hold, output logic [2:0] rel);
    logic [2:0] dt;
    drive(b, ch, 1'b0, we, ub, lb, a, d);
    tick();
    f_en   = b ? me_b : me_a;
    f_we   = b ? mw_b : mw_a;
    f_addr = b ? ma_b : ma_a;
    f_di   = b ? md_b : md_a;
    lat = 0;
    dt = b ? dt_b : dt_a;
    while (dt[ch] && lat < 40) begin
      tick();
      lat++;
      dt = b ? dt_b : dt_a;
    end
    rdata = b ? do_b : do_a;
    repeat (3) tick();
    hold = b ? dt_b : dt_a;
    drive(b, ch, 1'b1, we, ub, lb, a, d);
    tick();
    rel = b ? dt_b : dt_a;
    tick();
  endtask

  logic          f_en;
  logic [1:0]    f_we;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_di, rdata;
  logic [2:0]    hold, rel;
  int            lat, e0, n, ch;
  int            gcnt [NCH];
  bit            saw2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_a[i] = 16'h0000;
      ram_b[i] = 16'h0000;
    end
    mo_a = '0; mo_b = '0;
    ram_a[15'h0040] = 16'hBEEF;
    ram_a[15'h0010] = 16'hABCD;
    ram_b[15'h0040] = 16'hBEEF;
    ram_b[15'h0020] = 16'h5A5A;
    ram_b[15'h0030] = 16'h3333;
    ce_a = '1; we_a = '1; ub_a = '1; lb_a = '1; ad_a = '0; di_a = '0;
    ce_b = '1; we_b = '1; ub_b = '1; lb_b = '1; ad_b = '0; di_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dtack", 32'(dt_a), 32'h7);
    check("rst_mem_en", 32'(me_a), 32'h0);
    check("rst_mem_we", 32'(mw_a), 32'h0);
    check("rst_mem_addr", 32'(ma_a), 32'h0);
    check("rst_mem_di", 32'(md_a), 32'h0);
    check("rst_req_do", 32'(do_a), 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // ch1 read 0x0040 -> 0xBEEF, WAIT=0
    e0 = en_a;
    do_acc(1'b0, 1, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0, f_en, f_we, f_addr, f_di, lat, rdata, hold, rel);
    check("rd1_mem_en", 32'(f_en), 32'h1);
    check("rd1_mem_addr", 32'(f_addr), 32'h0040);
    check("rd1_mem_we", 32'(f_we), 32'h0);
    check("rd1_latency", 32'(lat), 32'd2);
    check("rd1_data", 32'(rdata), 32'hBEEF);
    check("rd1_hold", 32'(hold), 32'h5);
    check("rd1_release", 32'(rel), 32'h7);
    check("rd1_en_pulses", 32'(en_a - e0), 32'd1);

    // ch0 upper-byte write 0x1234 -> 0x0010
    do_acc(1'b0, 0, 1'b0, 1'b0, 1'b1, 15'h0010, 16'h1234, f_en, f_we, f_addr, f_di, lat, rdata, hold, rel);
    check("wr_mem_we", 32'(f_we), 32'h2);
    check("wr_mem_addr", 32'(f_addr), 32'h0010);
    check("wr_mem_di", 32'(f_di), 32'h1234);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_req_do_kept", 32'(rdata), 32'hBEEF);
    check("wr_hold", 32'(hold), 32'h6);

    // Readback: upper lane new, lower lane preserved
    do_acc(1'b0, 0, 1'b1, 1'b0, 1'b0, 15'h0010, 16'h0, f_en, f_we, f_addr, f_di, lat, rdata, hold, rel);
    check("rb_data", 32'(rdata), 32'h12CD);
    check("rb_latency", 32'(lat), 32'd2);

    // Reset pulse during ACK of a ch1 read
    drive(1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0);
    n = 0;
    while (dt_a[1] && n < 20) begin
      tick();
      n++;
    end
    check("rst_ack_reached", 32'(dt_a), 32'h5);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_ack_dtack", 32'(dt_a), 32'h7);
    check("rst_ack_mem_en", 32'(me_a), 32'h0);
    check("rst_ack_mem_we", 32'(mw_a), 32'h0);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0);
    drive(1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0041, 16'h0);
    drive(1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0042, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All channels requesting continuously from reset: strict 0,1,2 rotation
    for (int k = 0; k < NCH; k++) gcnt[k] = 0;
    for (int i = 0; i < 30; i++) begin
      n = 0;
      while (dt_a == 3'b111 && n < 30) begin
        tick();
        n++;
      end
      case (dt_a)
        3'b110:  ch = 0;
        3'b101:  ch = 1;
        3'b011:  ch = 2;
        default: ch = -1;
      endcase
      check("rr_order", 32'(ch), 32'(i % 3));
      if (ch >= 0) begin
        gcnt[ch]++;
        ce_a[ch] = 1'b1;
        tick();
        ce_a[ch] = 1'b0;
      end else begin
        tick();
      end
    end
    ce_a = '1;
    repeat (6) tick();
    check("rr_cnt_ch0", 32'(gcnt[0]), 32'd10);
    check("rr_cnt_ch1", 32'(gcnt[1]), 32'd10);
    check("rr_cnt_ch2", 32'(gcnt[2]), 32'd10);
    check("rr_no_overlap", 32'(ovl_a), 32'd0);

    // WAIT=3: single read latency
    e0 = en_b;
    do_acc(1'b1, 0, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0, f_en, f_we, f_addr, f_di, lat, rdata, hold, rel);
    check("w3_latency", 32'(lat), 32'd5);
    check("w3_data", 32'(rdata), 32'hBEEF);
    check("w3_en_pulses", 32'(en_b - e0), 32'd1);
    do_acc(1'b1, 1, 1'b1, 1'b0, 1'b0, 15'h0020, 16'h0, f_en, f_we, f_addr, f_di, lat, rdata, hold, rel);
    check("w3_ch1_data", 32'(rdata), 32'h5A5A);

    // ch2 aborts during WAITST while ch0 is pending
    e0 = en_b;
    drive(1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0030, 16'h0);
    drive(1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 16'h0);
    tick();
    check("ab_grant_addr", 32'(ma_b), 32'h0030);
    check("ab_mem_en", 32'(me_b), 32'h1);
    repeat (3) tick();
    ce_b[2] = 1'b1;
    n = 0;
    saw2 = 1'b0;
    while (dt_b[0] && n < 40) begin
      tick();
      n++;
      if (!dt_b[2]) saw2 = 1'b1;
    end
    check("ab_no_dtack2", 32'(saw2), 32'h0);
    check("ab_ch0_dtack_edge", 32'(n), 32'd8);
    check("ab_ch0_data", 32'(do_b), 32'hBEEF);
    check("ab_en_pulses", 32'(en_b - e0), 32'd2);
    ce_b = '1;
    repeat (3) tick();
    check("w3_no_overlap", 32'(ovl_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dtack_arbiter.md
MEM_DTACK_ARBITER -- requirements
Module: mem_dtack_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning number of requesters (ch0 VDP, ch1 68K, ch2 Z80); legal range 1-8.
REQ-002 SHALL have parameter AW, default 15, meaning word address width.
REQ-003 SHALL have parameter DW, default 16, meaning data width; must be even (two byte lanes).
REQ-004 SHALL have parameter WAIT, default 0, meaning extra wait cycles per access; legal range 0-15.
REQ-005 SHALL use clock CLK100MHZ, input, 1 bit, rising-edge system clock.
REQ-006 SHALL use reset CPU_RESETN, input, 1 bit, asynchronous, active-low.
REQ-007 SHALL have REQ_CE_N, input, NCH bits, per-channel active-low access request.
REQ-008 SHALL have REQ_WE_N, input, NCH bits, per-channel active-low write strobe.
REQ-009 SHALL have REQ_UB_N and REQ_LB_N, inputs, NCH bits each, per-channel active-low byte lanes.
REQ-010 SHALL have REQ_ADDR, input, NCH*AW bits, packed per-channel address (ch i at [i*AW +: AW]).
REQ-011 SHALL have REQ_DI, input, NCH*DW bits, packed per-channel write data.
REQ-012 SHALL have REQ_DO, output, DW bits, shared read data; valid while any REQ_DTACK_N bit is low.
REQ-013 SHALL have REQ_DTACK_N, output, NCH bits, per-channel active-low acknowledge.
REQ-014 SHALL have MEM_ADDR (AW), MEM_DI (DW), MEM_EN (1), MEM_WE (2, bit1 upper lane) as outputs, and MEM_DO (DW) as input, forming a 1-cycle-latency synchronous RAM port.

Function
REQ-015 SHALL treat all REQ_* inputs as synchronous to CLK100MHZ.
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAITST, ACK, RELEASE.
REQ-017 In IDLE with any REQ_CE_N bit low, SHALL grant the first requesting channel at or after (last_grant+1) mod NCH and move to ACCESS.
REQ-018 In ACCESS, SHALL drive MEM_EN=1 for exactly one cycle, with MEM_ADDR/MEM_DI from the granted channel.
REQ-019 In ACCESS, SHALL drive MEM_WE[1]=~WE_N&~UB_N and MEM_WE[0]=~WE_N&~LB_N for the granted channel.
REQ-020 SHALL go from ACCESS to WAITST when WAIT>0, counting WAIT cycles, and otherwise to ACK.
REQ-021 On the ACK entry edge, SHALL register MEM_DO into REQ_DO for reads and leave REQ_DO unchanged for writes.
REQ-022 Latency: with CE_N sampled low on edge k, DTACK_N SHALL go low after edge k+2+WAIT.
REQ-023 In ACK, the granted DTACK_N bit SHALL be held low until that channel's CE_N is sampled high.
REQ-024 When that CE_N is sampled high in ACK, DTACK_N SHALL go high on that edge, and the FSM SHALL move to RELEASE, then to IDLE after one cycle.
REQ-025 At most one REQ_DTACK_N bit SHALL be low at any time.
REQ-026 Abort: if the granted CE_N rises during ACCESS or WAITST, the RAM cycle SHALL complete, DTACK SHALL NOT assert, and the FSM SHALL go to RELEASE.
REQ-027 Requests from non-granted channels SHALL be held pending with no loss, because CE_N is level-sensitive.
REQ-028 last_grant SHALL update only on entry to ACCESS.
REQ-029 When NCH=1, the arbiter SHALL degenerate to a fixed grant with identical timing.

Reset
REQ-030 Asserting CPU_RESETN low SHALL immediately force state=IDLE, REQ_DTACK_N=all 1, MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_DI=0, REQ_DO=0, wait counter=0, and last_grant=NCH-1 (ch0 first after reset).
REQ-031 A reset asserted mid-access SHALL abandon the access with no DTACK pulse, and MEM_WE SHALL drop in the same cycle.
REQ-032 Reset deassertion SHALL be synchronised internally with a 2-flop release.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (mem_arb_state_t), MAX_NCH=8, and the WAIT width constant (4).
REQ-034 Round-robin selection SHALL live in one sub-module rr_select (NCH-bit request, pointer in, one-hot grant out, combinational).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 NCH=3, WAIT=0: ch1 reads 0x0040 preloaded 0xBEEF -> MEM_EN one cycle, DTACK_N[1] low 2 cycles after request, REQ_DO=0xBEEF, held until CE_N high.
REQ-037 ch0 writes 0x1234 to 0x0010 with UB_N=0, LB_N=1 -> MEM_WE=2'b10; readback returns 0x12xx with the old low byte preserved.
REQ-038 All three channels hold CE_N low from reset -> grants in order 0,1,2,0; no overlapping DTACK; no starvation over 30 accesses.
REQ-039 WAIT=3: single read -> DTACK_N low exactly 5 cycles after CE_N sampled low.
REQ-040 ch2 raises CE_N during WAITST -> no DTACK on any channel, next pending channel is granted after RELEASE.
REQ-041 CPU_RESETN pulsed low during ACK -> DTACK_N all 1 and MEM_EN=0 immediately; after release, ch0 is granted first.
